iq_sample_packer: RTL and testbench

Pairs the I- and Q-channel ADC samples into 64-bit words and writes them into the dual-clock ADC FIFO. It sits between the two ADC interface instances and the FIFO write port. Every transfer block starts with a header word that carries a sequence number and the overflow count. It detects FIFO overflow and I/Q pairing faults, so the host can tell when the stream has lost data.

---
 rtl/iq_sample_packer_pkg.sv | 26 ++
 rtl/iq_sample_packer_if.sv | 24 ++
 rtl/iq_sample_packer_pair_timeout_timer.sv | 37 +++
 rtl/iq_sample_packer.sv | 166 ++++++++++++++++
 tb/tb_iq_sample_packer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/iq_sample_packer_pkg.sv
// rtl/iq_sample_packer_pkg.sv - shared constants, FSM state type and header builder for the I/Q packer
package iq_sample_packer_pkg;

    localparam logic [15:0] HDR_MAGIC     = 16'hA55A;
    localparam int          HDR_MAGIC_LSB = 48;
    localparam int          HDR_OVF_LSB   = 32;
    localparam int          HDR_SEQ_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HDR     = 2'd2,
        ST_DATA    = 2'd3
    } state_e;

    // Block header: magic, overflow count at write time, block sequence number
    function automatic logic [63:0] make_header(input logic [15:0] ovf, input logic [31:0] seq);
        logic [63:0] hdr;
        hdr = '0;
        hdr[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
        hdr[HDR_OVF_LSB   +: 16] = ovf;
        hdr[HDR_SEQ_LSB   +: 32] = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/iq_sample_packer_if.sv
// rtl/iq_sample_packer_if.sv - ADC sample strobes and FIFO write port bundle
interface iq_sample_packer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   i_data;
    logic                    i_valid;
    logic [DATA_WIDTH-1:0]   q_data;
    logic                    q_valid;
    logic                    fifo_full;
    logic                    fifo_we;
    logic [2*DATA_WIDTH-1:0] fifo_data;

    // Environment side: drives samples and FIFO status, observes writes
    modport master (
        output i_data, i_valid, q_data, q_valid, fifo_full,
        input  fifo_we, fifo_data
    );

    // Packer side
    modport slave (
        input  i_data, i_valid, q_data, q_valid, fifo_full,
        output fifo_we, fifo_data
    );
endinterface

// File: rtl/iq_sample_packer_pair_timeout_timer.sv
// rtl/iq_sample_packer_pair_timeout_timer.sv - counts how long a lone I or Q sample waits for its partner
module pair_timeout_timer #(
    parameter int PAIR_TIMEOUT = 255
) (
    input  logic clk,
    input  logic arstn,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int            CW   = $clog2(PAIR_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(PAIR_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expire on the edge where the wait reaches PAIR_TIMEOUT cycles
    assign expire_o = run_i && (cnt_q == LAST);

    // Count only while running; any stop, clear or expiry restarts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !run_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/iq_sample_packer.sv
// rtl/iq_sample_packer.sv - pairs I/Q samples into 64-bit FIFO words with per-block headers
module iq_sample_packer
    import iq_sample_packer_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 1024,
    parameter int PAIR_TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 enable,
    iq_sample_packer_if.slave    bus,
    output logic [15:0]          overflow_cnt,
    output logic                 pair_err,
    output logic [31:0]          seq_cnt
);
    localparam int               WC_W    = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WORDS_PER_BLOCK - 1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   i_hold_q, i_hold_d, q_hold_q, q_hold_d;
    logic                    i_flg_q, i_flg_d, q_flg_q, q_flg_d;
    logic [2*DATA_WIDTH-1:0] pair_q, pair_d;
    logic [2*DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
    logic                    fifo_we_q, fifo_we_d;
    logic                    pair_err_q, pair_err_d;
    logic [15:0]             ovf_q, ovf_d;
    logic [31:0]             seq_q, seq_d;
    logic [WC_W-1:0]         wc_q, wc_d;
    logic                    capture_en, take_pair, tmo_run, tmo_expire;

    assign capture_en = (state_q != ST_IDLE);
    assign take_pair  = (state_q == ST_COLLECT) && i_flg_q && q_flg_q;
    assign tmo_run    = capture_en && (i_flg_q ^ q_flg_q);

    pair_timeout_timer #(
        .PAIR_TIMEOUT (PAIR_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .arstn    (arstn),
        .run_i    (tmo_run),
        .clr_i    (!capture_en),
        .expire_o (tmo_expire)
    );

    // Sample capture, pair consumption, timeout and overwrite fault detection
    always_comb begin
        i_hold_d   = i_hold_q;
        q_hold_d   = q_hold_q;
        i_flg_d    = i_flg_q;
        q_flg_d    = q_flg_q;
        pair_err_d = pair_err_q;
        if (!capture_en) begin
            i_flg_d = 1'b0;
            q_flg_d = 1'b0;
        end else begin
            if (take_pair || tmo_expire) begin
                i_flg_d = 1'b0;
                q_flg_d = 1'b0;
            end
            if (tmo_expire) begin
                pair_err_d = 1'b1;
            end
            // A strobe landing on the consuming edge starts the next pair, not a fault
            if (bus.i_valid) begin
                if (i_flg_q && !take_pair) pair_err_d = 1'b1;
                i_hold_d = bus.i_data;
                i_flg_d  = 1'b1;
            end
            if (bus.q_valid) begin
                if (q_flg_q && !take_pair) pair_err_d = 1'b1;
                q_hold_d = bus.q_data;
                q_flg_d  = 1'b1;
            end
        end
    end

    // FSM next state and registered FIFO write / counter updates
    always_comb begin
        state_d     = state_q;
        fifo_we_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        pair_d      = pair_q;
        ovf_d       = ovf_q;
        seq_d       = seq_q;
        wc_d        = wc_q;
        if (!enable) begin
            state_d = ST_IDLE;
            wc_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    wc_d    = '0;
                    state_d = ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (take_pair) begin
                        pair_d  = {i_hold_q, q_hold_q};
                        state_d = (wc_q == '0) ? ST_HDR : ST_DATA;
                    end
                end
                ST_HDR: begin
                    if (!bus.fifo_full) begin
                        fifo_we_d   = 1'b1;
                        fifo_data_d = (2*DATA_WIDTH)'(make_header(ovf_q, seq_q));
                        seq_d       = seq_q + 32'd1;
                        wc_d        = WC_W'(1);
                        state_d     = ST_DATA;
                    end else begin
                        // Header not written, so the next pair retries it
                        if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
                        state_d = ST_COLLECT;
                    end
                end
                ST_DATA: begin
                    if (!bus.fifo_full) begin
                        fifo_we_d   = 1'b1;
                        fifo_data_d = pair_q;
                        wc_d        = (wc_q == WC_LAST) ? '0 : wc_q + WC_W'(1);
                    end else begin
                        if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
                    end
                    state_d = ST_COLLECT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= ST_IDLE;
            i_hold_q    <= '0;
            q_hold_q    <= '0;
            i_flg_q     <= 1'b0;
            q_flg_q     <= 1'b0;
            pair_q      <= '0;
            fifo_we_q   <= 1'b0;
            fifo_data_q <= '0;
            pair_err_q  <= 1'b0;
            ovf_q       <= '0;
            seq_q       <= '0;
            wc_q        <= '0;
        end else begin
            state_q     <= state_d;
            i_hold_q    <= i_hold_d;
            q_hold_q    <= q_hold_d;
            i_flg_q     <= i_flg_d;
            q_flg_q     <= q_flg_d;
            pair_q      <= pair_d;
            fifo_we_q   <= fifo_we_d;
            fifo_data_q <= fifo_data_d;
            pair_err_q  <= pair_err_d;
            ovf_q       <= ovf_d;
            seq_q       <= seq_d;
            wc_q        <= wc_d;
        end
    end

    assign bus.fifo_we   = fifo_we_q;
    assign bus.fifo_data = fifo_data_q;
    assign overflow_cnt  = ovf_q;
    assign pair_err      = pair_err_q;
    assign seq_cnt       = seq_q;
endmodule

// File: tb/tb_iq_sample_packer.sv
// tb/tb_iq_sample_packer.sv - self-checking bench for iq_sample_packer
module tb_iq_sample_packer;
    localparam int WPB = 4;

    logic        clk;
    logic        arstn;
    logic        enable;
    logic [15:0] overflow_cnt;
    logic        pair_err;
    logic [31:0] seq_cnt;

    iq_sample_packer_if #(.DATA_WIDTH(32)) bus();

    iq_sample_packer #(
        .DATA_WIDTH      (32),
        .WORDS_PER_BLOCK (WPB),
        .PAIR_TIMEOUT    (255)
    ) dut (
        .clk          (clk),
        .arstn        (arstn),
        .enable       (enable),
        .bus          (bus),
        .overflow_cnt (overflow_cnt),
        .pair_err     (pair_err),
        .seq_cnt      (seq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests;
    int          fails;
    logic [63:0] exp_q[$];
    logic [63:0] got[$];
    int          m_seq;
    int          m_ovf;
    int          m_idx;
    int          base;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Block-level model: header at the start of each block, one data word per pair
    task automatic model_pair(input logic [31:0] i, input logic [31:0] q);
        if (m_idx == 0) begin
            if (bus.fifo_full) begin
                if (m_ovf < 65535) m_ovf++;
                return;
            end
            exp_q.push_back({16'hA55A, m_ovf[15:0], m_seq[31:0]});
            m_seq++;
            m_idx = 1;
        end
        if (bus.fifo_full) begin
            if (m_ovf < 65535) m_ovf++;
        end else begin
            exp_q.push_back({i, q});
            m_idx = (m_idx + 1) % WPB;
        end
    endtask

    task automatic pair(input logic [31:0] i, input logic [31:0] q);
        @(negedge clk);
        bus.i_data = i; bus.q_data = q; bus.i_valid = 1'b1; bus.q_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0; bus.q_valid = 1'b0;
        model_pair(i, q);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_counters(input string name);
        check({name, "_seq"}, 64'(seq_cnt), 64'(m_seq));
        check({name, "_ovf"}, 64'(overflow_cnt), 64'(m_ovf));
    endtask

    initial begin
        tests = 0; fails = 0;
        m_seq = 0; m_ovf = 0; m_idx = 0;
        arstn = 1'b0; enable = 1'b0;
        bus.i_data = '0; bus.q_data = '0; bus.i_valid = 1'b0; bus.q_valid = 1'b0;
        bus.fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we",   64'(bus.fifo_we), 64'd0);
        check("rst_data", bus.fifo_data, 64'd0);
        check("rst_ovf",  64'(overflow_cnt), 64'd0);
        check("rst_err",  64'(pair_err), 64'd0);
        check("rst_seq",  64'(seq_cnt), 64'd0);
        arstn = 1'b1;

        // Every cycle with a write: compare against the model and bound burst length
        fork
            begin
                int run;
                run = 0;
                forever begin
                    @(negedge clk);
                    if (bus.fifo_we) begin
                        got.push_back(bus.fifo_data);
                        run++;
                        check("burst_le2", 64'(run <= 2), 64'd1);
                        if (exp_q.size() == 0) begin
                            check("unexpected_write", bus.fifo_data, 64'hX);
                        end else begin
                            check("write_word", bus.fifo_data, exp_q.pop_front());
                        end
                    end else begin
                        run = 0;
                    end
                end
            end
        join_none

        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Basic block: header then three data words
        for (int n = 0; n < 3; n++) pair(32'h11, 32'h22);
        check("basic_hdr", got[0], 64'hA55A_0000_0000_0000);
        check("basic_d0",  got[1], 64'h0000_0011_0000_0022);
        check("basic_d2",  got[3], 64'h0000_0011_0000_0022);
        check("basic_seq", 64'(seq_cnt), 64'd1);
        check_counters("basic");

        // Skewed strobes, Q 40 cycles after I, block start so header at k+2, data at k+3
        @(negedge clk);
        bus.i_data = 32'hAAAA_0001; bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (39) @(negedge clk);
        bus.q_data = 32'hBBBB_0001; bus.q_valid = 1'b1;
        @(negedge clk);
        bus.q_valid = 1'b0;
        model_pair(32'hAAAA_0001, 32'hBBBB_0001);
        @(negedge clk);
        check("skew_k1_we", 64'(bus.fifo_we), 64'd0);
        @(negedge clk);
        check("skew_k2_we",  64'(bus.fifo_we), 64'd1);
        check("skew_k2_hdr", bus.fifo_data, 64'hA55A_0000_0000_0001);
        @(negedge clk);
        check("skew_k3_we",   64'(bus.fifo_we), 64'd1);
        check("skew_k3_data", bus.fifo_data, 64'hAAAA_0001_BBBB_0001);
        repeat (4) @(negedge clk);
        check("skew_no_err", 64'(pair_err), 64'd0);

        // Lone I sample times out and raises pair_err without writing
        @(negedge clk);
        bus.i_data = 32'hDEAD_0000; bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (249) @(negedge clk);
        check("tmo_before", 64'(pair_err), 64'd0);
        repeat (10) @(negedge clk);
        check("tmo_after", 64'(pair_err), 64'd1);

        // FIFO full across five data pairs
        bus.fifo_full = 1'b1;
        for (int n = 0; n < 5; n++) pair(32'h100 + n, 32'h200 + n);
        check("full_ovf", 64'(overflow_cnt), 64'd5);
        check_counters("full");
        bus.fifo_full = 1'b0;
        pair(32'h3, 32'h4);
        pair(32'h5, 32'h6);
        pair(32'h7, 32'h8);
        check("full_next_hdr", got[got.size() - 2], 64'hA55A_0005_0000_0002);
        check_counters("after_full");

        // Disable during the header cycle: no write, next header keeps the sequence number
        pair(32'h9, 32'hA);
        pair(32'hB, 32'hC);
        @(negedge clk);
        bus.i_data = 32'hEE; bus.q_data = 32'hFF; bus.i_valid = 1'b1; bus.q_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0; bus.q_valid = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("dis_no_we", 64'(bus.fifo_we), 64'd0);
        @(negedge clk);
        enable = 1'b1;
        m_idx = 0;
        repeat (2) @(negedge clk);
        pair(32'h12, 32'h34);
        check("reen_hdr", got[got.size() - 2], 64'hA55A_0005_0000_0003);
        check("reen_seq", 64'(seq_cnt), 64'd4);

        // Asynchronous reset mid-block clears every output at once
        pair(32'h56, 32'h78);
        @(negedge clk);
        #2 arstn = 1'b0;
        #1;
        check("arst_we",   64'(bus.fifo_we), 64'd0);
        check("arst_data", bus.fifo_data, 64'd0);
        check("arst_ovf",  64'(overflow_cnt), 64'd0);
        check("arst_err",  64'(pair_err), 64'd0);
        check("arst_seq",  64'(seq_cnt), 64'd0);
        @(negedge clk);
        arstn = 1'b1;
        m_seq = 0; m_ovf = 0; m_idx = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);

        // Block wrap: 7 pairs give H0 D D D H1 D D D H2 D
        base = got.size();
        for (int n = 0; n < 7; n++) pair(32'h1000 + n, 32'h2000 + n);
        check("wrap_count", 64'(got.size() - base), 64'd10);
        check("wrap_h0", got[base],     64'hA55A_0000_0000_0000);
        check("wrap_h1", got[base + 4], 64'hA55A_0000_0000_0001);
        check("wrap_h2", got[base + 8], 64'hA55A_0000_0000_0002);
        check("wrap_d6", got[base + 9], 64'h0000_1006_0000_2006);
        check_counters("wrap");
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
